inputs_skew_unit: RTL and testbench
===================================

# inputs_skew_unit

Diagonal skew stage between the im2col input unit and the 3x3 systolic array. Takes the 9-byte parallel window produced each cycle by the im2col unit and delays lane k by k extra cycles, producing the staggered wavefront the array's west edge requires. It also tracks the end of each stream and pulses a done flag once the last sample has left the deepest lane.

## Interface
Parameters:
- LANES, 9, number of window lanes / array rows; must be ≥ 2.
- DW, 8, signed data width per lane.

Ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  window valid; driven from the im2col unit's started_o.
- i_data  in  DW×LANES (signed unpacked array [LANES-1:0])  window bytes; lane k = im2col output k.
- i_stall  in  1  array hold request; freezes the whole block.
- o_ready  out  1  = !i_stall (combinational); a sample is accepted when i_valid && o_ready.
- o_data  out  DW×LANES (signed)  skewed lanes; 0 in any slot not carrying a valid sample.
- o_valid  out  LANES  per-lane valid of o_data.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse at end of stream.

## Operation
- Lane k is a (k+1)-deep register chain with a per-stage valid bit. All stages advance only when i_stall=0.
- On an advancing cycle, stage 0 of every lane loads i_data[k] and i_valid. Data is loaded as 0 when i_valid=0, so bubbles carry zeros.
- When i_stall=1:
  - All data, valid bits, the FSM and the counter hold.
  - i_valid is ignored, and upstream must hold its sample.
- FSM, with states IDLE, RUN, DRAIN and DONE:
  - IDLE → RUN on an accepted sample.
  - RUN stays in RUN while samples are accepted. RUN → DRAIN on an advancing cycle with i_valid=0. A bubble ends the stream.
  - DRAIN:
    - DRAIN → RUN on an accepted sample. This merges the streams: no o_done for the first, and the counter clears.
    - Otherwise the drain counter increments on each advancing cycle.
    - DRAIN → DONE when the counter reaches LANES-1.
  - DONE lasts one cycle with o_done=1.
    - DONE → RUN if a sample is accepted that cycle.
    - DONE → IDLE otherwise.
    - If i_stall=1 in DONE, the FSM holds in DONE and o_done stays high until the first non-stalled cycle.
- Drain counter width is $clog2(LANES). It resets to 0 on entry to DRAIN.
- Samples are never dropped or duplicated. Every accepted sample appears exactly once on each lane.

## Timing
- Reset values:
  - All stage data and valid bits are 0.
  - o_data=0, o_valid=0, o_busy=0, o_done=0.
  - State = IDLE, counter = 0.
  - o_ready follows i_stall even during reset.
- Latency (no stalls): a sample accepted in cycle t appears on lane k in cycle t+1+k. Lane 0 is therefore one registered cycle.
- Each stall cycle adds one cycle to every in-flight sample's latency.
- End of stream, no stalls: last sample accepted in cycle t.
  - Bubble at t+1.
  - DRAIN during t+2..t+LANES.
  - Last lane valid during t+LANES.
  - o_done=1 during t+LANES+1 (t+10 for LANES=9), exactly one cycle after the last valid on lane LANES-1.
- Reset asserted mid-stream:
  - Immediate, asynchronous clear.
  - In-flight samples are discarded, and no o_done is produced.
- Single-sample stream behaves identically to the end-of-stream case with t equal to its acceptance cycle.

## Structure
- cvxif_pkg gains the FSM type skew_state_t (IDLE, RUN, DRAIN, DONE) and the constant SA_LANES=9. Top-level instantiation uses LANES=SA_LANES.
- Sub-module skew_lane, parameterised by DW and DEPTH:
  - It is an enable-gated delay chain carrying data and valid with async active-high reset.
  - It is generated LANES times with DEPTH=k+1.
- The FSM, drain counter and o_ready/o_busy/o_done live in inputs_skew_unit.

## Test plan
- Reset: assert i_rst mid-cycle with i_valid=1 and random data → all outputs 0 immediately, state IDLE; after release with idle inputs, outputs stay 0.
- Single window: i_data[k]=k+1 for one cycle at t → lane k shows value k+1 with o_valid[k]=1 only in cycle t+1+k; o_done=1 only in cycle t+10; o_busy high t+1..t+10.
- Burst of 4 windows: lane values 10·n+k for n=0..3 in cycles t..t+3 → lane k carries 10n+k in cycle t+n+1+k; o_done only in cycle t+13.
- Stall: same burst with i_stall=1 for 2 cycles at t+5 → o_ready=0 in those cycles; all outputs frozen across them; every later output shifted 2 cycles; o_done in cycle t+15; no sample lost.
- Merge: single window at t, bubble, then new window accepted at t+4 during DRAIN → no o_done until 10 cycles after the t+4 sample (cycle t+14); both samples appear on every lane.
- Negative data: lanes driven to -128 and -1 → reproduced bit-exact; no-valid slots read 0.

Source files
------------

// File: rtl/cvxif_pkg.sv
// Shared types and constants for the systolic-array input path.
package cvxif_pkg;

  localparam int SA_LANES = 9;
  localparam int SA_DW    = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } skew_state_t;

endpackage

// File: rtl/inputs_skew_unit_if.sv
// Window-in / skewed-lanes-out bus between im2col, the skew stage and the array.
interface inputs_skew_unit_if
  import cvxif_pkg::*;
#(
  parameter int LANES = SA_LANES,
  parameter int DW    = SA_DW
);

  logic                 i_valid;
  logic signed [DW-1:0] i_data [LANES-1:0];
  logic                 i_stall;
  logic                 o_ready;
  logic signed [DW-1:0] o_data [LANES-1:0];
  logic [LANES-1:0]     o_valid;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_valid, i_data, i_stall,
    input  o_ready, o_data, o_valid, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_data, i_stall,
    output o_ready, o_data, o_valid, o_busy, o_done
  );

endinterface

// File: rtl/inputs_skew_unit_lane.sv
// One skew lane: an enable-gated DEPTH-stage delay chain for data plus valid.
module skew_lane #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid
);

  logic signed [DW-1:0] data_q [DEPTH-1:0];
  logic [DEPTH-1:0]     vld_pipe;

  // Shift data and valid one stage per advancing cycle; hold when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      vld_pipe <= '0;
    end else if (en) begin
      data_q[0]   <= in_data;
      vld_pipe[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]   <= data_q[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = vld_pipe[DEPTH-1];

endmodule

// File: rtl/inputs_skew_unit.sv
// Diagonal skew stage: lane k delayed k+1 cycles, with end-of-stream tracking.
module inputs_skew_unit
  import cvxif_pkg::*;
#(
  parameter int LANES = SA_LANES,
  parameter int DW    = SA_DW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  inputs_skew_unit_if.slave bus
);

  localparam int            CW   = $clog2(LANES);
  // Counter value of the last DRAIN cycle; the next increment reaches LANES-1.
  localparam logic [CW-1:0] LAST = CW'(LANES - 2);

  skew_state_t          state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 adv, acc;
  logic signed [DW-1:0] lane_in [LANES-1:0];

  assign adv         = !bus.i_stall;
  assign acc         = bus.i_valid && adv;
  assign bus.o_ready = adv;
  assign bus.o_busy  = (state != IDLE);
  assign bus.o_done  = (state == DONE);

  // Bubbles enter the lanes as zeros so empty slots always read 0.
  always_comb begin
    for (int k = 0; k < LANES; k++) lane_in[k] = bus.i_valid ? bus.i_data[k] : '0;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    skew_lane #(.DW(DW), .DEPTH(k + 1)) u_lane (
      .clk      (i_clk),
      .rst      (i_rst),
      .en       (adv),
      .in_data  (lane_in[k]),
      .in_valid (bus.i_valid),
      .out_data (bus.o_data[k]),
      .out_valid(bus.o_valid[k])
    );
  end

  // State and drain counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stream tracking: a bubble ends a stream, LANES-1 drain cycles flush the deepest lane.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (adv) begin
      case (state)
        IDLE: if (acc) state_nxt = RUN;
        RUN: begin
          if (!bus.i_valid) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end
        end
        DRAIN: begin
          if (acc) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) state_nxt = DONE;
          end
        end
        DONE:    state_nxt = acc ? RUN : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inputs_skew_unit.sv
// Randomised and directed bench for inputs_skew_unit against a tick-history model.
module tb_inputs_skew_unit;
  import cvxif_pkg::*;

  localparam int L  = SA_LANES;
  localparam int DW = SA_DW;

  typedef logic [L-1:0][DW-1:0] win_t;

  logic clk, rst;
  int   n_tests, n_fail, cyc, done_at;

  inputs_skew_unit_if #(.LANES(L), .DW(DW)) bus ();

  inputs_skew_unit #(.LANES(L), .DW(DW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one entry per advancing cycle; lane k shows the entry k ticks back.
  win_t hist_d [$];
  bit   hist_v [$];
  int   bub;          // advancing bubbles since last accepted sample; > L means idle

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    hist_d.delete();
    hist_v.delete();
    bub = L + 1;
  endtask

  task automatic drive(input bit v, input bit st, input win_t w);
    bus.i_valid = v;
    bus.i_stall = st;
    for (int k = 0; k < L; k++) bus.i_data[k] = w[k];
  endtask

  function automatic win_t rand_win();
    win_t w;
    for (int k = 0; k < L; k++) w[k] = DW'($urandom);
    return w;
  endfunction

  task automatic check_outputs();
    win_t          ed, gd;
    logic [L-1:0]  ev;
    int            idx;
    for (int k = 0; k < L; k++) begin
      idx = hist_v.size() - 1 - k;
      ev[k] = (idx >= 0) ? hist_v[idx] : 1'b0;
      ed[k] = ev[k] ? hist_d[idx][k] : '0;
      gd[k] = bus.o_data[k];
    end
    chk("o_data",  128'(gd), 128'(ed));
    chk("o_valid", 128'(bus.o_valid), 128'(ev));
    chk("o_busy",  128'(bus.o_busy), 128'(bub <= L));
    chk("o_done",  128'(bus.o_done), 128'(bub == L));
    chk("o_ready", 128'(bus.o_ready), 128'(!bus.i_stall));
    if (bus.o_done && done_at < 0) done_at = cyc;
  endtask

  task automatic model_step();
    win_t w;
    if (rst) begin
      model_clear();
    end else if (!bus.i_stall) begin
      for (int k = 0; k < L; k++) w[k] = bus.i_valid ? bus.i_data[k] : '0;
      hist_d.push_back(w);
      hist_v.push_back(bus.i_valid);
      if (hist_v.size() > L) begin
        void'(hist_d.pop_front());
        void'(hist_v.pop_front());
      end
      if (bus.i_valid) bub = 0;
      else if (bub <= L) bub++;
    end
  endtask

  // Inputs are applied #1 after a rising edge, checked at the falling edge,
  // and consumed by the model at the next rising edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, '0);
      tick();
    end
  endtask

  initial begin
    win_t w;
    int   t0, pv;
    n_tests = 0; n_fail = 0; cyc = 0; done_at = -1;
    model_clear();
    rst = 1'b1;
    drive(1'b1, 1'b1, rand_win());
    #2;
    chk("rst_ready_stalled", 128'(bus.o_ready), 128'(0));
    bus.i_stall = 1'b0;
    #1;
    chk("rst_ready", 128'(bus.o_ready), 128'(1));
    tick();
    tick();
    rst = 1'b0;
    idle(3);

    // Reset mid-stream with valid data in flight.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, rand_win());
      tick();
    end
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid", 128'(bus.o_valid), 128'(0));
    chk("midrst_busy",  128'(bus.o_busy), 128'(0));
    chk("midrst_lane0", 128'(bus.o_data[0]), 128'(0));
    model_clear();
    tick();
    rst = 1'b0;
    done_at = -1;
    idle(14);
    chk("midrst_no_done", 128'(done_at), 128'(-1));

    // Single window, lane k = k+1.
    for (int k = 0; k < L; k++) w[k] = DW'(k + 1);
    done_at = -1; t0 = cyc;
    drive(1'b1, 1'b0, w); tick();
    idle(14);
    chk("single_done_lat", 128'(done_at - t0), 128'(10));

    // Burst of four windows, lane values 10n+k.
    done_at = -1; t0 = cyc;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < L; k++) w[k] = DW'(10 * n + k);
      drive(1'b1, 1'b0, w); tick();
    end
    idle(14);
    chk("burst_done_lat", 128'(done_at - t0), 128'(13));

    // Same burst with a 2-cycle stall at t+5; valid during stall must be ignored.
    done_at = -1; t0 = cyc;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < L; k++) w[k] = DW'(10 * n + k);
      drive(1'b1, 1'b0, w); tick();
    end
    idle(1);
    drive(1'b1, 1'b1, rand_win()); tick();
    drive(1'b1, 1'b1, rand_win()); tick();
    idle(14);
    chk("stall_done_lat", 128'(done_at - t0), 128'(15));

    // Merge: second window accepted during drain.
    done_at = -1; t0 = cyc;
    drive(1'b1, 1'b0, rand_win()); tick();
    idle(3);
    drive(1'b1, 1'b0, rand_win()); tick();
    idle(14);
    chk("merge_done_lat", 128'(done_at - t0), 128'(14));

    // Negative extremes.
    for (int k = 0; k < L; k++) w[k] = (k % 2) ? 8'hFF : 8'h80;
    done_at = -1; t0 = cyc;
    drive(1'b1, 1'b0, w); tick();
    idle(12);
    chk("neg_done_lat", 128'(done_at - t0), 128'(10));

    // Random segments of varying density, stalls, and occasional long gaps.
    for (int seg = 0; seg < 60; seg++) begin
      pv = $urandom_range(0, 100);
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
        drive(($urandom % 100) < pv, ($urandom % 100) < 15, rand_win());
        tick();
      end
      if (($urandom % 100) < 30) idle($urandom_range(8, 12));
    end
    idle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
